gh_psx_pad: RTL
===============

# gh_psx_pad

PlayStation 2 controller-port slave that sits directly downstream of the video-analysis player stage. It snapshots the player's Frets/Strum/Whammy/Tilt outputs and serves them to the console over the PSX serial bus (ATT/CLK/CMD in, DAT/ACK out). It answers the 0x42 poll in digital (ID 0x41) or analog (ID 0x73) form. Strum pulses are held sticky until a poll has reported them.

## Interface
- ANALOG, 0, 1 = answer with ID 0x73 plus four stick bytes; 0 = ID 0x41
- ACK_DELAY, 100, CLK cycles from byte completion to ACK assertion
- ACK_WIDTH, 200, CLK cycles ACK is held low
- CLK  in  1  system clock; one clock domain, ≥8× PSX bus clock
- RST  in  1  reset, asynchronous, active-high
- Frets  in  5  {orange, blue, yellow, red, green}, 1 = pressed
- Strum  in  1  strum pulse from player, any width ≥1 CLK
- Whammy  in  8  whammy position
- Tilt  in  1  tilt/star-power, 1 = active
- PsxAtt  in  1  console select, active-low, asynchronous
- PsxClk  in  1  console bus clock, asynchronous, idle high
- PsxCmd  in  1  console command bit, asynchronous
- PsxDat  out  1  response bit; 1 = released (board makes it open-drain)
- PsxAck  out  1  acknowledge; 0 = asserted, 1 = released
- Status  out  4  {strumSticky, state[2:0]} for debug

## Operation
- PsxAtt, PsxClk and PsxCmd each pass through a 2-flop synchronizer and an edge detector.
- Bus timing: bytes are LSB first. DAT changes on PsxClk falling edge; CMD is sampled on PsxClk rising edge.
- States:
  - IDLE. On ATT falling, snapshot Frets/Whammy/Tilt/strumSticky into the report registers, load byte 0xFF, go to HDR.
  - HDR. If cmd byte = 0x01, go to ID; otherwise go to WAIT_ATT.
  - ID. Drive ID byte. If cmd = 0x42, go to SIG; otherwise go to WAIT_ATT.
  - SIG. Drive 0x5A, then go to DATA.
  - DATA. Bytes 3..4 in digital mode, 3..8 in analog mode. The last byte goes to WAIT_ATT.
  - WAIT_ATT. PsxDat held at 1 until ATT rises, then IDLE.
- ATT rising in any state: go to IDLE immediately, release PsxDat and PsxAck, clear the ACK counter.
- Byte 3 (active-low) bit assignments:
  - bit0 Select = Tilt
  - bit6 D-down = strumSticky
  - all other bits 1
- Byte 4 (active-low) bit assignments:
  - bit1 R2 = green
  - bit5 Circle = red
  - bit4 Triangle = yellow
  - bit6 Cross = blue
  - bit7 Square = orange
  - bits 0, 2, 3 = 1
- Analog bytes 5..8 = RX = Whammy, then RY, LX, LY = 0x80.
- ACK is pulsed after every completed byte except the final one and except bytes leading to WAIT_ATT.
- strumSticky:
  - Set on a Strum rising edge.
  - Cleared when byte 3 completes with the snapshot bit = 1.
  - Set and clear in the same cycle: set wins.
  - ATT abort before byte 3 completes: no clear.

## Timing
- Reset values: PsxDat=1, PsxAck=1, Status=0, strumSticky=0, state=IDLE.
- PsxDat reflects the new bit within 4 CLK of a pin-level PsxClk fall: 2 cycles sync, 1 cycle edge detect, 1 cycle register.
- Bit 0 of each byte is driven within 4 CLK of the ATT fall (byte 0) or of the preceding byte's 8th rising edge.
- PsxAck falls exactly ACK_DELAY CLK after the byte's 8th rising edge is detected, and stays low ACK_WIDTH CLK.
- A PsxClk fall during ACK does not shorten the pulse.
- Snapshot is fixed for the whole transaction; input changes during a poll appear in the next poll.
- A bit counter (3-bit) and a byte counter (4-bit) wrap only via the state transitions above. There is no free-running wrap.
- RST mid-transaction returns all outputs to reset values within the same CLK cycle, because reset is asynchronous.

## Structure
- Shared package gh_psx_pkg holds:
  - constants PSX_ID_DIG=0x41, PSX_ID_ANA=0x73, PSX_SIG=0x5A, CMD_START=0x01, CMD_POLL=0x42
  - button bit-position constants
  - the state enumeration
- Sub-module gh_psx_sync: 2-flop synchronizer with rise/fall pulse outputs, instantiated for ATT, CLK and CMD.

## Test plan
- Digital poll, Frets=5'b00101, no strum, Tilt=0 → DAT bytes FF 41 5A FF ED; ACK pulses after bytes 0–3 only, each 200 CLK low after 100 CLK.
- Strum 1-CLK pulse, then poll with Tilt=1, Frets=0 → byte 3 = BE, byte 4 = FF. A second poll gives byte 3 = FE.
- ANALOG=1, Whammy=0x3C → bytes FF 73 5A FF FF 3C 80 80 80; no ACK after byte 8.
- Cmd byte 0 = 0x81 → DAT stays 1 and no ACK until ATT rises. The next correct poll answers normally.
- ATT rises mid byte 2 with strumSticky=1 → immediate IDLE, PsxDat=PsxAck=1, strumSticky remains 1. The next poll reports byte 3 = BF.
- RST asserted at bit 5 of byte 3 → PsxDat=1, PsxAck=1, Status=0 asynchronously; the poll after release is well-formed.

Source files
------------

// File: rtl/gh_psx_pkg.sv
// gh_psx_pkg: constants, report-byte bit positions and state encodings for the
// guitar-to-PSX controller-port slave.
// Shared by gh_psx_pad and its sub-modules.
package gh_psx_pkg;

    localparam logic [7:0] PSX_ID_DIG       = 8'h41;
    localparam logic [7:0] PSX_ID_ANA       = 8'h73;
    localparam logic [7:0] PSX_SIG          = 8'h5A;
    localparam logic [7:0] CMD_START        = 8'h01;
    localparam logic [7:0] CMD_POLL         = 8'h42;
    localparam logic [7:0] PSX_IDLE_BYTE    = 8'hFF;
    localparam logic [7:0] PSX_STICK_CENTER = 8'h80;

    // Frets input ordering {orange, blue, yellow, red, green}
    localparam int FRET_GREEN  = 0;
    localparam int FRET_RED    = 1;
    localparam int FRET_YELLOW = 2;
    localparam int FRET_BLUE   = 3;
    localparam int FRET_ORANGE = 4;

    // Byte 3 / byte 4 button positions (all active-low on the wire)
    localparam int B3_SELECT   = 0;
    localparam int B3_DDOWN    = 6;
    localparam int B4_R2       = 1;
    localparam int B4_TRIANGLE = 4;
    localparam int B4_CIRCLE   = 5;
    localparam int B4_CROSS    = 6;
    localparam int B4_SQUARE   = 7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_ID       = 3'd2,
        ST_SIG      = 3'd3,
        ST_DATA     = 3'd4,
        ST_WAIT_ATT = 3'd5
    } psx_state_e;

    typedef enum logic [1:0] {
        ACK_IDLE = 2'd0,
        ACK_WAIT = 2'd1,
        ACK_LOW  = 2'd2
    } ack_phase_e;

    function automatic logic [7:0] byte3_fn(input logic tilt, input logic strum);
        logic [7:0] b;
        b            = 8'hFF;
        b[B3_SELECT] = ~tilt;
        b[B3_DDOWN]  = ~strum;
        return b;
    endfunction

    function automatic logic [7:0] byte4_fn(input logic [4:0] frets);
        logic [7:0] b;
        b              = 8'hFF;
        b[B4_R2]       = ~frets[FRET_GREEN];
        b[B4_CIRCLE]   = ~frets[FRET_RED];
        b[B4_TRIANGLE] = ~frets[FRET_YELLOW];
        b[B4_CROSS]    = ~frets[FRET_BLUE];
        b[B4_SQUARE]   = ~frets[FRET_ORANGE];
        return b;
    endfunction

endpackage

// File: rtl/gh_psx_sync.sv
// gh_psx_sync: 2-flop synchronizer for one asynchronous bus pin, plus a
// registered edge detector. Ports: clk_i, rst_i, d_i -> q_o (synced level),
// rise_o / fall_o (one-cycle pulses, 3 clk_i after the pin changes).
module gh_psx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    // [0],[1] synchronize; [2] is the edge-detect history. All PSX pins idle high.
    logic [2:0] sync_q;
    logic       rise_q;
    logic       fall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 3'b111;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
            rise_q <= sync_q[1] & ~sync_q[2];
            fall_q <= ~sync_q[1] & sync_q[2];
        end
    end

    // q_o is aligned with rise_o/fall_o so a level sampled on an edge pulse
    // sees the pin value from the same pin-time.
    assign q_o    = sync_q[2];
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/gh_psx_pad.sv
// gh_psx_pad: PS2 controller-port slave serving snapshotted guitar state.
// Ports: CLK/RST, player inputs Frets/Strum/Whammy/Tilt, PSX bus PsxAtt/PsxClk/
// PsxCmd in, PsxDat/PsxAck out (1 = released), Status = {strumSticky, state}.
module gh_psx_pad
    import gh_psx_pkg::*;
#(
    parameter bit ANALOG    = 1'b0,
    parameter int ACK_DELAY = 100,
    parameter int ACK_WIDTH = 200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] Frets,
    input  logic       Strum,
    input  logic [7:0] Whammy,
    input  logic       Tilt,
    input  logic       PsxAtt,
    input  logic       PsxClk,
    input  logic       PsxCmd,
    output logic       PsxDat,
    output logic       PsxAck,
    output logic [3:0] Status
);
    localparam logic [3:0] LAST_BYTE = ANALOG ? 4'd8 : 4'd4;
    localparam logic [7:0] ID_BYTE   = ANALOG ? PSX_ID_ANA : PSX_ID_DIG;

    logic att_rise, att_fall, clk_rise, clk_fall, cmd_lvl;
    logic unused_att_lvl, unused_clk_lvl, unused_cmd_rise, unused_cmd_fall;

    gh_psx_sync u_att (.clk_i(CLK), .rst_i(RST), .d_i(PsxAtt), .q_o(unused_att_lvl),
                       .rise_o(att_rise), .fall_o(att_fall));
    gh_psx_sync u_clk (.clk_i(CLK), .rst_i(RST), .d_i(PsxClk), .q_o(unused_clk_lvl),
                       .rise_o(clk_rise), .fall_o(clk_fall));
    gh_psx_sync u_cmd (.clk_i(CLK), .rst_i(RST), .d_i(PsxCmd), .q_o(cmd_lvl),
                       .rise_o(unused_cmd_rise), .fall_o(unused_cmd_fall));

    psx_state_e state_q, state_d;
    ack_phase_e ack_phase_q, ack_phase_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  tx_q, tx_d, rx_q, rx_d;
    logic        dat_q, dat_d, ack_q, ack_d;
    logic [15:0] ack_cnt_q, ack_cnt_d;
    logic [4:0]  frets_q, frets_d;
    logic [7:0]  whammy_q, whammy_d;
    logic        tilt_q, tilt_d, strum_snap_q, strum_snap_d;
    logic        sticky_q, sticky_d, strum_prev_q;

    logic [7:0] rx_byte, next_tx;
    logic       ack_start, sticky_clr;

    // Report bytes 3..8 from the per-transaction snapshot.
    function automatic logic [7:0] data_byte(input logic [3:0] idx, input logic tilt,
                                             input logic strum, input logic [4:0] frets,
                                             input logic [7:0] whammy);
        case (idx)
            4'd3:    return byte3_fn(tilt, strum);
            4'd4:    return byte4_fn(frets);
            4'd5:    return whammy;
            default: return PSX_STICK_CENTER;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        ack_phase_d  = ack_phase_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        dat_d        = dat_q;
        ack_d        = ack_q;
        ack_cnt_d    = ack_cnt_q;
        frets_d      = frets_q;
        whammy_d     = whammy_q;
        tilt_d       = tilt_q;
        strum_snap_d = strum_snap_q;
        rx_byte      = {cmd_lvl, rx_q[7:1]};
        next_tx      = PSX_IDLE_BYTE;
        ack_start    = 1'b0;
        sticky_clr   = 1'b0;

        if (att_rise) begin
            // Deselect aborts everything, from any state.
            state_d     = ST_IDLE;
            dat_d       = 1'b1;
            ack_d       = 1'b1;
            ack_phase_d = ACK_IDLE;
            ack_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (att_fall) begin
                        frets_d      = Frets;
                        whammy_d     = Whammy;
                        tilt_d       = Tilt;
                        strum_snap_d = sticky_q;
                        tx_d         = PSX_IDLE_BYTE;
                        dat_d        = PSX_IDLE_BYTE[0];
                        bit_cnt_d    = '0;
                        byte_cnt_d   = '0;
                        state_d      = ST_HDR;
                    end
                end
                ST_WAIT_ATT: dat_d = 1'b1;
                default: begin
                    if (clk_fall) begin
                        dat_d = tx_q[bit_cnt_q];
                    end else if (clk_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 4'd1;
                            case (state_q)
                                ST_HDR: begin
                                    state_d   = (rx_byte == CMD_START) ? ST_ID : ST_WAIT_ATT;
                                    next_tx   = ID_BYTE;
                                    ack_start = (rx_byte == CMD_START);
                                end
                                ST_ID: begin
                                    state_d   = (rx_byte == CMD_POLL) ? ST_SIG : ST_WAIT_ATT;
                                    next_tx   = PSX_SIG;
                                    ack_start = (rx_byte == CMD_POLL);
                                end
                                ST_SIG: begin
                                    state_d   = ST_DATA;
                                    next_tx   = data_byte(4'd3, tilt_q, strum_snap_q,
                                                          frets_q, whammy_q);
                                    ack_start = 1'b1;
                                end
                                default: begin
                                    // Only a completed byte 3 counts as the strum being reported.
                                    sticky_clr = (byte_cnt_q == 4'd3) && strum_snap_q;
                                    if (byte_cnt_q == LAST_BYTE) begin
                                        state_d = ST_WAIT_ATT;
                                    end else begin
                                        next_tx   = data_byte(byte_cnt_q + 4'd1, tilt_q,
                                                              strum_snap_q, frets_q, whammy_q);
                                        ack_start = 1'b1;
                                    end
                                end
                            endcase
                            // Bit 0 of the next byte goes out now, ahead of its first fall.
                            tx_d  = next_tx;
                            dat_d = (state_d == ST_WAIT_ATT) ? 1'b1 : next_tx[0];
                        end
                    end
                end
            endcase

            // ACK pulse timer: runs independently of bus clock edges once started.
            if (ack_start) begin
                ack_phase_d = ACK_WAIT;
                ack_cnt_d   = 16'(ACK_DELAY - 1);
                ack_d       = 1'b1;
            end else begin
                case (ack_phase_q)
                    ACK_WAIT: begin
                        if (ack_cnt_q == '0) begin
                            ack_d       = 1'b0;
                            ack_phase_d = ACK_LOW;
                            ack_cnt_d   = 16'(ACK_WIDTH - 1);
                        end else begin
                            ack_cnt_d = ack_cnt_q - 16'd1;
                        end
                    end
                    ACK_LOW: begin
                        if (ack_cnt_q == '0) begin
                            ack_d       = 1'b1;
                            ack_phase_d = ACK_IDLE;
                        end else begin
                            ack_cnt_d = ack_cnt_q - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // A new strum in the same cycle as the clear must not be lost.
        if (Strum && !strum_prev_q) sticky_d = 1'b1;
        else if (sticky_clr)        sticky_d = 1'b0;
        else                        sticky_d = sticky_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            ack_phase_q  <= ACK_IDLE;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            tx_q         <= PSX_IDLE_BYTE;
            rx_q         <= '0;
            dat_q        <= 1'b1;
            ack_q        <= 1'b1;
            ack_cnt_q    <= '0;
            frets_q      <= '0;
            whammy_q     <= '0;
            tilt_q       <= 1'b0;
            strum_snap_q <= 1'b0;
            sticky_q     <= 1'b0;
            strum_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_phase_q  <= ack_phase_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            dat_q        <= dat_d;
            ack_q        <= ack_d;
            ack_cnt_q    <= ack_cnt_d;
            frets_q      <= frets_d;
            whammy_q     <= whammy_d;
            tilt_q       <= tilt_d;
            strum_snap_q <= strum_snap_d;
            sticky_q     <= sticky_d;
            strum_prev_q <= Strum;
        end
    end

    assign PsxDat = dat_q;
    assign PsxAck = ack_q;
    assign Status = {sticky_q, state_q};
endmodule
